// File: rtl/cam_capture_ctrl_if.sv
// Control, camera-timing and status bundle for the capture sequencer.
// master drives the requests and camera pins; slave is the sequencer.
interface cam_capture_ctrl_if #(
  parameter int unsigned P_FCNT_W = 16
);
  logic                CAPSTART;
  logic                CAPSTOP;
  logic                CAPMODE;
  logic [1:0]          RESOL;
  logic                VSYNC;
  logic                HREF;
  logic                FIFOFULL;
  logic                FIFOWR;
  logic                CAPON;
  logic                BUSY;
  logic                FRAME_DONE;
  logic [P_FCNT_W-1:0] FRAME_CNT;
  logic [10:0]         LINE_CNT;
  logic                ERR_LINE;
  logic                ERR_OVF;

  modport master (
    output CAPSTART, CAPSTOP, CAPMODE, RESOL, VSYNC, HREF, FIFOFULL, FIFOWR,
    input  CAPON, BUSY, FRAME_DONE, FRAME_CNT, LINE_CNT, ERR_LINE, ERR_OVF
  );

  modport slave (
    input  CAPSTART, CAPSTOP, CAPMODE, RESOL, VSYNC, HREF, FIFOFULL, FIFOWR,
    output CAPON, BUSY, FRAME_DONE, FRAME_CNT, LINE_CNT, ERR_LINE, ERR_OVF
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-level capture sequencer: arms on start, skips settling frames, then gates
// CAPON for whole frames while counting frames and lines and flagging errors.
module cam_capture_ctrl #(
  parameter int unsigned P_SKIP_FRAMES = 1,
  parameter int unsigned P_FCNT_W      = 16
) (
  input logic               PCLK,
  input logic               PRSTN,
  cam_capture_ctrl_if.slave cap
);

  localparam logic [1:0] P_RESOL_VGA  = 2'd0;
  localparam logic [1:0] P_RESOL_XGA  = 2'd1;
  localparam logic [1:0] P_RESOL_SXGA = 2'd2;

  localparam logic [3:0]          SkipFrames = 4'(P_SKIP_FRAMES);
  localparam logic [P_FCNT_W-1:0] FcntOne    = P_FCNT_W'(1);
  localparam logic [10:0]         LineMax    = 11'd2047;

  typedef enum logic [2:0] {StIdle, StArm, StSkip, StWaitF, StCapt} state_e;

  state_e              state_q, state_d;
  logic                vs_q, href_q;
  logic                mode_q, mode_d;
  logic [1:0]          resol_q, resol_d;
  logic [3:0]          skip_q, skip_d;
  logic                stop_pend_q, stop_pend_d;
  logic                capon_q, capon_d;
  logic                frame_done_q, frame_done_d;
  logic [P_FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [10:0]         line_q, line_d;
  logic                err_line_q, err_line_d;
  logic                err_ovf_q, err_ovf_d;

  logic                vs_rise, vs_fall, href_fall;
  logic [3:0]          skip_inc;
  logic [10:0]         exp_lines;

  // Edges are decoded against the previous-cycle pin value, one cycle behind the pin.
  assign vs_rise   = cap.VSYNC & ~vs_q;
  assign vs_fall   = ~cap.VSYNC & vs_q;
  assign href_fall = ~cap.HREF & href_q;
  assign skip_inc  = skip_q + 4'd1;

  always_comb begin
    case (resol_q)
      P_RESOL_VGA:  exp_lines = 11'd480;
      P_RESOL_XGA:  exp_lines = 11'd768;
      P_RESOL_SXGA: exp_lines = 11'd1024;
      default:      exp_lines = 11'd1024;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    resol_d      = resol_q;
    skip_d       = skip_q;
    stop_pend_d  = stop_pend_q;
    capon_d      = capon_q;
    frame_done_d = 1'b0;
    fcnt_d       = fcnt_q;
    line_d       = line_q;
    err_line_d   = err_line_q;
    err_ovf_d    = err_ovf_q;

    unique case (state_q)
      StIdle: begin
        if (cap.CAPSTART) begin
          state_d    = StArm;
          mode_d     = cap.CAPMODE;
          resol_d    = cap.RESOL;
          fcnt_d     = '0;
          err_line_d = 1'b0;
          err_ovf_d  = 1'b0;
          skip_d     = 4'd0;
        end
      end
      StArm: begin
        if (cap.CAPSTOP) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          state_d = (SkipFrames != 4'd0) ? StSkip : StWaitF;
        end
      end
      StSkip: begin
        if (cap.CAPSTOP) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          skip_d = skip_inc;
          if (skip_inc == SkipFrames) begin
            state_d = StWaitF;
          end
        end
      end
      StWaitF: begin
        if (cap.CAPSTOP) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d = StCapt;
          capon_d = 1'b1;
          line_d  = 11'd0;
        end
      end
      StCapt: begin
        if (cap.CAPSTOP) begin
          stop_pend_d = 1'b1;
        end
        if (cap.FIFOWR && cap.FIFOFULL) begin
          err_ovf_d = 1'b1;
        end
        if (href_fall && (line_q != LineMax)) begin
          line_d = line_q + 11'd1;
        end
        if (vs_rise) begin
          frame_done_d = 1'b1;
          fcnt_d       = fcnt_q + FcntOne;
          capon_d      = 1'b0;
          if (line_q != exp_lines) begin
            err_line_d = 1'b1;
          end
          // A stop arriving on the closing edge itself still ends the run.
          state_d = (mode_q && !stop_pend_q && !cap.CAPSTOP) ? StWaitF : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRSTN) begin
    if (!PRSTN) begin
      state_q      <= StIdle;
      vs_q         <= 1'b0;
      href_q       <= 1'b0;
      mode_q       <= 1'b0;
      resol_q      <= 2'd0;
      skip_q       <= 4'd0;
      stop_pend_q  <= 1'b0;
      capon_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
      line_q       <= 11'd0;
      err_line_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= cap.VSYNC;
      href_q       <= cap.HREF;
      mode_q       <= mode_d;
      resol_q      <= resol_d;
      skip_q       <= skip_d;
      stop_pend_q  <= stop_pend_d;
      capon_q      <= capon_d;
      frame_done_q <= frame_done_d;
      fcnt_q       <= fcnt_d;
      line_q       <= line_d;
      err_line_q   <= err_line_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign cap.CAPON      = capon_q;
  assign cap.BUSY       = (state_q != StIdle);
  assign cap.FRAME_DONE = frame_done_q;
  assign cap.FRAME_CNT  = fcnt_q;
  assign cap.LINE_CNT   = line_q;
  assign cap.ERR_LINE   = err_line_q;
  assign cap.ERR_OVF    = err_ovf_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: frame-level reference model feeds a scoreboard that
// a FRAME_DONE monitor drains; status is also compared at fixed points per frame.
module tb_cam_capture_ctrl;

  localparam int unsigned SKIP = 1;
  localparam int unsigned FCW  = 16;

  logic PCLK  = 1'b0;
  logic PRSTN = 1'b0;
  always #5 PCLK = ~PCLK;

  cam_capture_ctrl_if #(.P_FCNT_W(FCW)) ifc ();

  cam_capture_ctrl #(
    .P_SKIP_FRAMES(SKIP),
    .P_FCNT_W     (FCW)
  ) dut (
    .PCLK (PCLK),
    .PRSTN(PRSTN),
    .cap  (ifc)
  );

  typedef struct {
    int fcnt;
    int lines;
    bit errl;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Frame-level model of the sequencer.
  bit         m_busy, m_capt, m_willcap, m_mode, m_stop, m_errl, m_ovf;
  int         m_seen, m_fcnt, m_lines;
  logic [1:0] m_resol;

  // Per-frame stimulus events; -1 means "before this frame's VSYNC".
  int         ev_start = -9, ev_stop = -9, ev_ovf = -9, ev_rst = -9;
  bit         ev_ovf_vs = 1'b0;
  bit         ev_mode   = 1'b0;
  logic [1:0] ev_resol  = 2'd0;

  function automatic int exp_lines(input logic [1:0] r);
    case (r)
      2'd0:    return 480;
      2'd1:    return 768;
      default: return 1024;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic model_reset();
    m_busy = 0; m_capt = 0; m_willcap = 0; m_mode = 0; m_stop = 0;
    m_errl = 0; m_ovf = 0; m_seen = 0; m_fcnt = 0; m_lines = 0; m_resol = 2'd0;
  endtask

  task automatic model_start(input bit md, input logic [1:0] r);
    if (!m_busy) begin
      m_busy = 1; m_mode = md; m_resol = r; m_fcnt = 0; m_errl = 0; m_ovf = 0;
      m_seen = 0; m_capt = 0; m_willcap = 0; m_stop = 0;
    end
  endtask

  task automatic model_stop();
    if (m_capt) m_stop = 1;
    else if (m_busy) begin
      m_busy = 0;
      m_willcap = 0;
    end
  endtask

  task automatic model_vs_rise();
    if (m_capt) begin
      m_fcnt = (m_fcnt + 1) % (1 << FCW);
      if (m_lines != exp_lines(m_resol)) m_errl = 1;
      q.push_back('{m_fcnt, (m_lines > 2047) ? 2047 : m_lines, m_errl, m_ovf});
      m_capt = 0;
      if (m_mode && !m_stop) m_willcap = 1;
      else begin
        m_busy = 0;
        m_stop = 0;
      end
    end else if (m_busy) begin
      m_seen++;
      m_willcap = (m_seen > SKIP);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_capon"}, ifc.CAPON, m_capt);
    chk({tag, "_busy"}, ifc.BUSY, m_busy);
    chk({tag, "_fcnt"}, ifc.FRAME_CNT, m_fcnt);
    chk({tag, "_lcnt"}, ifc.LINE_CNT, (m_lines > 2047) ? 2047 : m_lines);
    chk({tag, "_errline"}, ifc.ERR_LINE, m_errl);
    chk({tag, "_errovf"}, ifc.ERR_OVF, m_ovf);
  endtask

  task automatic do_reset();
    #2 PRSTN = 1'b0;
    #1;
    chk("rst_capon", ifc.CAPON, 0);
    chk("rst_busy", ifc.BUSY, 0);
    chk("rst_fcnt", ifc.FRAME_CNT, 0);
    chk("rst_done", ifc.FRAME_DONE, 0);
    model_reset();
    tick();
    PRSTN = 1'b1;
  endtask

  task automatic send_frame(input int nlines);
    if (ev_start == -1) begin
      ifc.CAPSTART = 1'b1; ifc.CAPMODE = ev_mode; ifc.RESOL = ev_resol;
      model_start(ev_mode, ev_resol);
      tick();
      ifc.CAPSTART = 1'b0;
    end
    model_vs_rise();
    ifc.VSYNC = 1'b1;
    tick();
    tick();
    if (ev_ovf_vs) begin
      ifc.FIFOWR = 1'b1; ifc.FIFOFULL = 1'b1;
    end
    tick();
    ifc.FIFOWR = 1'b0; ifc.FIFOFULL = 1'b0;
    check_status("vsync");
    tick();
    ifc.VSYNC = 1'b0;
    chk("capon_before_vsfall", ifc.CAPON, 0);
    tick();
    if (m_willcap) begin
      m_capt = 1; m_lines = 0; m_willcap = 0;
    end
    chk("capon_after_vsfall", ifc.CAPON, m_capt);
    tick();
    tick();
    for (int l = 0; l < nlines; l++) begin
      if (l == ev_rst) do_reset();
      ifc.HREF = 1'b1;
      if (l == ev_start) begin
        ifc.CAPSTART = 1'b1; ifc.CAPMODE = ev_mode; ifc.RESOL = ev_resol;
        model_start(ev_mode, ev_resol);
      end
      if (l == ev_stop) begin
        ifc.CAPSTOP = 1'b1;
        model_stop();
      end
      if (l == ev_ovf) begin
        ifc.FIFOWR = 1'b1; ifc.FIFOFULL = 1'b1;
        if (m_capt) m_ovf = 1;
      end
      tick();
      ifc.CAPSTART = 1'b0; ifc.CAPSTOP = 1'b0; ifc.FIFOWR = 1'b0; ifc.FIFOFULL = 1'b0;
      if (l % 128 == 10) check_status("line");
      tick();
      ifc.HREF = 1'b0;
      if (m_capt) m_lines++;
      tick();
    end
    repeat (3) tick();
    ev_start = -9; ev_stop = -9; ev_ovf = -9; ev_rst = -9; ev_ovf_vs = 1'b0;
  endtask

  // Scoreboard drain: every FRAME_DONE must match the oldest expected frame.
  always @(negedge PCLK) begin : monitor
    exp_t e;
    if (ifc.FRAME_DONE) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got FRAME_DONE=1 required 0 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("done_fcnt", ifc.FRAME_CNT, e.fcnt);
        chk("done_lcnt", ifc.LINE_CNT, e.lines);
        chk("done_errline", ifc.ERR_LINE, e.errl);
        chk("done_errovf", ifc.ERR_OVF, e.ovf);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int deltas[4];
    int r, md, nfr, nl;
    deltas = '{0, 0, -1, 2};
    ifc.CAPSTART = 1'b0; ifc.CAPSTOP = 1'b0; ifc.CAPMODE = 1'b0; ifc.RESOL = 2'd0;
    ifc.VSYNC = 1'b0; ifc.HREF = 1'b0; ifc.FIFOFULL = 1'b0; ifc.FIFOWR = 1'b0;
    model_reset();
    repeat (3) tick();
    check_status("reset");
    chk("reset_done", ifc.FRAME_DONE, 0);
    PRSTN = 1'b1;
    repeat (2) tick();

    // Single frame, VGA: one skipped frame then one captured.
    ev_start = -1; ev_mode = 0; ev_resol = 2'd0;
    send_frame(16);
    send_frame(480);
    send_frame(0);
    check_status("single_end");

    // Continuous SXGA, stop during the third captured frame.
    ev_start = -1; ev_mode = 1; ev_resol = 2'd2;
    send_frame(16);
    send_frame(1024);
    send_frame(1024);
    ev_stop = 512;
    send_frame(1024);
    send_frame(1024);
    check_status("cont_end");

    // XGA short frame sets ERR_LINE; it stays until the next start.
    ev_start = -1; ev_mode = 0; ev_resol = 2'd1;
    send_frame(16);
    send_frame(767);
    send_frame(0);
    send_frame(0);
    check_status("errline_sticky");

    // Overflow strobe in WAITF is ignored; in CAPT it sets ERR_OVF.
    ev_start = -1; ev_mode = 0; ev_resol = 2'd0;
    send_frame(16);
    ev_ovf_vs = 1'b1; ev_ovf = 100;
    send_frame(480);
    send_frame(0);

    // Mid-frame arm, then an ignored second start while busy.
    ev_start = 100; ev_mode = 1; ev_resol = 2'd0;
    send_frame(200);
    send_frame(16);
    ev_start = 50; ev_mode = 0; ev_resol = 2'd1;
    send_frame(480);
    ev_stop = 300;
    send_frame(480);
    send_frame(0);

    // Reset during capture at line 200.
    ev_start = -1; ev_mode = 1; ev_resol = 2'd0;
    send_frame(16);
    ev_rst = 200;
    send_frame(480);
    send_frame(0);
    check_status("post_reset");

    // Randomized runs.
    for (int it = 0; it < 4; it++) begin
      r  = $urandom_range(0, 3);
      md = $urandom_range(0, 1);
      ev_start = -1; ev_mode = md[0]; ev_resol = r[1:0];
      send_frame(8 + $urandom_range(0, 8));
      nfr = md ? 2 : 1;
      for (int k = 0; k < nfr; k++) begin
        nl = exp_lines(r[1:0]) + deltas[$urandom_range(0, 3)];
        if ($urandom_range(0, 1) == 1) ev_ovf = $urandom_range(0, nl - 1);
        if (md == 1 && k == nfr - 1) ev_stop = $urandom_range(0, nl - 1);
        send_frame(nl);
      end
      send_frame(0);
      check_status("rand_end");
    end

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
